// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX/MEM bus and holds loads until the data-RAM response is in hand and WB takes them.
// Non-loads leave after one cycle; loads leave on the response cycle or later, stalling EX via MEM_allow_in meanwhile.
module mem_stage #(
    parameter int EX_TO_MEM_BUS_WD = 80,
    parameter int MEM_TO_WB_BUS_WD = 111,
    parameter int MEM_TO_BY_BUS_WD = 39
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus,
    input  logic                        EX_to_MEM_valid,
    output logic                        MEM_allow_in,
    input  logic                        data_rsp_valid,
    input  logic [31:0]                 data_rsp_rdata,
    output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
    output logic                        MEM_to_WB_valid,
    input  logic                        WB_allow_in,
    output logic [MEM_TO_BY_BUS_WD-1:0] MEM_to_BY_bus
);

    typedef struct packed {
        logic [2:0]  valid_stage;
        logic        rf_w_en;
        logic        sel_rf_w_data;
        logic        sel_data_ram_wd;
        logic [3:0]  b_en;
        logic        is_load;
        logic [4:0]  w_addr;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } ex_mem_t;

    typedef struct packed {
        logic [2:0]  valid_stage;
        logic        rf_w_en;
        logic        sel_rf_w_data;
        logic        sel_data_ram_wd;
        logic [3:0]  b_en;
        logic [31:0] r_data;
        logic [4:0]  w_addr;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } mem_wb_t;

    typedef struct packed {
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        logic        data_valid;
        logic        rf_w_en;
    } mem_by_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HAVE = 2'd2
    } state_e;

    ex_mem_t     ex_bus;
    ex_mem_t     bus_q, bus_d;
    logic        mem_valid_q, mem_valid_d;
    state_e      state_q, state_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        rsp_hit;
    logic        ready_go;
    logic        allow_in;
    logic        accept;
    logic        load_accept;
    logic        handoff;
    logic [31:0] r_data;
    logic        word_load;
    mem_wb_t     wb_bus;
    mem_by_t     by_bus;

    assign ex_bus = EX_to_MEM_bus;

    // A response only counts while a load is actually waiting for it.
    assign rsp_hit  = (state_q == S_WAIT) & data_rsp_valid;
    assign ready_go = ~bus_q.is_load | rsp_hit | (state_q == S_HAVE);
    assign allow_in = ~mem_valid_q | (ready_go & WB_allow_in);
    assign handoff  = mem_valid_q & ready_go & WB_allow_in;

    assign accept      = EX_to_MEM_valid & allow_in;
    assign load_accept = accept & ex_bus.is_load;

    always_comb begin
        mem_valid_d = mem_valid_q;
        bus_d       = bus_q;
        rdata_buf_d = rdata_buf_q;
        if (allow_in) begin
            mem_valid_d = EX_to_MEM_valid;
        end
        if (accept) begin
            bus_d = ex_bus;
        end
        if (rsp_hit) begin
            rdata_buf_d = data_rsp_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_rsp_valid) begin
                    if (WB_allow_in) begin
                        state_d = load_accept ? S_WAIT : S_IDLE;
                    end else begin
                        state_d = S_HAVE;
                    end
                end
            end
            S_HAVE: begin
                if (WB_allow_in) begin
                    state_d = load_accept ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid_q <= 1'b0;
            state_q     <= S_IDLE;
            bus_q       <= '0;
            rdata_buf_q <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            state_q     <= state_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // Forward the response combinationally so a load can leave in its response cycle.
    always_comb begin
        r_data = 32'h0;
        if (bus_q.is_load) begin
            r_data = rsp_hit ? data_rsp_rdata : rdata_buf_q;
        end
    end

    always_comb begin
        wb_bus                 = '0;
        wb_bus.valid_stage     = bus_q.valid_stage;
        wb_bus.rf_w_en         = bus_q.rf_w_en;
        wb_bus.sel_rf_w_data   = bus_q.sel_rf_w_data;
        wb_bus.sel_data_ram_wd = bus_q.sel_data_ram_wd;
        wb_bus.b_en            = bus_q.b_en;
        wb_bus.r_data          = r_data;
        wb_bus.w_addr          = bus_q.w_addr;
        wb_bus.alu_result      = bus_q.alu_result;
        wb_bus.pc              = bus_q.pc;
    end

    // Sub-word loads are realigned in WB, so their raw word is not yet bypassable.
    assign word_load = bus_q.is_load & (bus_q.b_en == 4'b1111);

    always_comb begin
        by_bus            = '0;
        by_bus.w_addr     = bus_q.w_addr;
        by_bus.w_data     = bus_q.is_load ? r_data : bus_q.alu_result;
        by_bus.data_valid = mem_valid_q & ready_go
                          & (bus_q.valid_stage[1] | bus_q.valid_stage[2])
                          & (~bus_q.is_load | word_load);
        by_bus.rf_w_en    = bus_q.rf_w_en;
    end

    assign MEM_allow_in    = allow_in;
    assign MEM_to_WB_valid = mem_valid_q & ready_go;
    assign MEM_to_WB_bus   = wb_bus;
    assign MEM_to_BY_bus   = by_bus;

    logic unused_handoff;
    assign unused_handoff = handoff;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed corner cases plus a randomized run checked by an in-order scoreboard.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic [79:0]  ex_bus;
    logic         ex_vld;
    logic         allow_in;
    logic         rsp_vld;
    logic [31:0]  rsp_rdata;
    logic [110:0] wb_bus;
    logic         wb_vld;
    logic         wb_allow;
    logic [38:0]  by_bus;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .EX_to_MEM_bus   (ex_bus),
        .EX_to_MEM_valid (ex_vld),
        .MEM_allow_in    (allow_in),
        .data_rsp_valid  (rsp_vld),
        .data_rsp_rdata  (rsp_rdata),
        .MEM_to_WB_bus   (wb_bus),
        .MEM_to_WB_valid (wb_vld),
        .WB_allow_in     (wb_allow),
        .MEM_to_BY_bus   (by_bus)
    );

    typedef struct {
        logic [2:0]  vs;
        logic        rfw;
        logic        selw;
        logic        selram;
        logic [3:0]  ben;
        logic        ld;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
    } instr_t;

    int     total = 0;
    int     bad   = 0;
    bit     mon_en = 1'b0;
    instr_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [79:0] ex_vec(input instr_t i);
        return {i.vs, i.rfw, i.selw, i.selram, i.ben, i.ld, i.wa, i.alu, i.pc};
    endfunction

    function automatic logic [110:0] wb_exp(input instr_t i);
        logic [31:0] rd;
        rd = i.ld ? i.rdata : 32'h0;
        return {i.vs, i.rfw, i.selw, i.selram, i.ben, rd, i.wa, i.alu, i.pc};
    endfunction

    // Bypass view of an instruction that is ready to leave MEM.
    function automatic logic [38:0] by_exp(input instr_t i);
        logic [31:0] wd;
        logic        dv;
        wd = i.ld ? i.rdata : i.alu;
        dv = (i.vs[1] | i.vs[2]) & !(i.ld && i.ben != 4'hF);
        return {i.wa, wd, dv, i.rfw};
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.vs     = 3'($urandom);
        i.rfw    = 1'($urandom);
        i.selw   = 1'($urandom);
        i.selram = 1'($urandom);
        i.ben    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        i.ld     = 1'($urandom);
        i.wa     = 5'($urandom);
        i.alu    = $urandom;
        i.pc     = $urandom;
        i.rdata  = $urandom;
        return i;
    endfunction

    function automatic instr_t mk(input logic ld, input logic [31:0] alu, input logic [4:0] wa,
                                  input logic [31:0] rdata);
        instr_t i;
        i.vs = 3'b010; i.rfw = 1'b1; i.selw = ld; i.selram = 1'b0; i.ben = 4'hF;
        i.ld = ld; i.wa = wa; i.alu = alu; i.pc = 32'h1c00_0000 + alu; i.rdata = rdata;
        return i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: the front entry must be on the bus whenever MEM offers to WB.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (wb_vld) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 128'(wb_vld), 128'(0));
                end else begin
                    chk("sb_wb_bus", 128'(wb_bus), 128'(wb_exp(exp_q[0])));
                    chk("sb_by_bus", 128'(by_bus), 128'(by_exp(exp_q[0])));
                    if (wb_allow) void'(exp_q.pop_front());
                end
            end else begin
                chk("sb_by_idle_dv", 128'(by_bus[1]), 128'(0));
            end
        end
    end

    instr_t a, b, cur;
    int     rsp_cnt;
    logic [31:0] rsp_data;

    initial begin
        reset = 1'b0; ex_vld = 1'b0; ex_bus = '0; rsp_vld = 1'b0; rsp_rdata = '0; wb_allow = 1'b1;
        #1;
        chk("rst_allow_in", 128'(allow_in), 128'(1));
        chk("rst_wb_vld", 128'(wb_vld), 128'(0));
        chk("rst_wb_bus", 128'(wb_bus), 128'(0));
        chk("rst_by_bus", 128'(by_bus), 128'(0));
        @(negedge clk); reset = 1'b1;

        // ALU op passes in one cycle
        step();
        a = mk(1'b0, 32'h1234, 5'd5, 32'h0);
        ex_vld = 1'b1; ex_bus = ex_vec(a);
        @(negedge clk); chk("t1_allow_pre", 128'(allow_in), 128'(1));
        step(); ex_vld = 1'b0;
        @(negedge clk);
        chk("t1_wb_vld", 128'(wb_vld), 128'(1));
        chk("t1_allow", 128'(allow_in), 128'(1));
        chk("t1_wb_bus", 128'(wb_bus), 128'(wb_exp(a)));
        chk("t1_by_bus", 128'(by_bus), 128'(by_exp(a)));
        step();
        @(negedge clk); chk("t1_wb_vld_after", 128'(wb_vld), 128'(0));

        // Word load with three idle cycles before the response
        step();
        a = mk(1'b1, 32'h0000_0100, 5'd7, 32'hDEAD_BEEF);
        ex_vld = 1'b1; ex_bus = ex_vec(a);
        for (int k = 0; k < 3; k++) begin
            step(); ex_vld = 1'b0;
            @(negedge clk);
            chk("t2_allow_stall", 128'(allow_in), 128'(0));
            chk("t2_wb_vld_stall", 128'(wb_vld), 128'(0));
        end
        step(); rsp_vld = 1'b1; rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_wb_vld", 128'(wb_vld), 128'(1));
        chk("t2_allow", 128'(allow_in), 128'(1));
        chk("t2_wb_bus", 128'(wb_bus), 128'(wb_exp(a)));
        step(); rsp_vld = 1'b0; rsp_rdata = 32'h0;
        @(negedge clk); chk("t2_wb_vld_after", 128'(wb_vld), 128'(0));

        // Response arrives while WB is blocked: data must be held
        a = mk(1'b1, 32'h0000_0200, 5'd9, 32'hDEAD_BEEF);
        ex_vld = 1'b1; ex_bus = ex_vec(a);
        step(); ex_vld = 1'b0; rsp_vld = 1'b1; rsp_rdata = 32'hDEAD_BEEF; wb_allow = 1'b0;
        @(negedge clk);
        chk("t3_n_wb_vld", 128'(wb_vld), 128'(1));
        chk("t3_n_allow", 128'(allow_in), 128'(0));
        step(); rsp_vld = 1'b0; rsp_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("t3_n1_wb_vld", 128'(wb_vld), 128'(1));
        chk("t3_n1_wb_bus", 128'(wb_bus), 128'(wb_exp(a)));
        chk("t3_n1_allow", 128'(allow_in), 128'(0));
        step(); wb_allow = 1'b1;
        @(negedge clk);
        chk("t3_n2_allow", 128'(allow_in), 128'(1));
        chk("t3_n2_wb_bus", 128'(wb_bus), 128'(wb_exp(a)));
        step();
        @(negedge clk); chk("t3_after_vld", 128'(wb_vld), 128'(0));

        // Stray response while idle changes nothing
        step(); rsp_vld = 1'b1; rsp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t5_wb_vld", 128'(wb_vld), 128'(0));
        chk("t5_allow", 128'(allow_in), 128'(1));
        chk("t5_wb_bus", 128'(wb_bus), 128'(wb_exp(a)));
        step(); rsp_vld = 1'b0;
        @(negedge clk); chk("t5_wb_bus_after", 128'(wb_bus), 128'(wb_exp(a)));

        // Back-to-back loads, one-cycle response each
        a = mk(1'b1, 32'h0000_0300, 5'd11, 32'hA1A1_A1A1);
        b = mk(1'b1, 32'h0000_0400, 5'd12, 32'hB2B2_B2B2);
        ex_vld = 1'b1; ex_bus = ex_vec(a);
        step(); ex_vld = 1'b1; ex_bus = ex_vec(b); rsp_vld = 1'b1; rsp_rdata = a.rdata;
        @(negedge clk);
        chk("t4_a_wb_bus", 128'(wb_bus), 128'(wb_exp(a)));
        chk("t4_a_allow", 128'(allow_in), 128'(1));
        step(); ex_vld = 1'b0; rsp_vld = 1'b0;
        @(negedge clk);
        chk("t4_b_wait_vld", 128'(wb_vld), 128'(0));
        step(); rsp_vld = 1'b1; rsp_rdata = b.rdata;
        @(negedge clk);
        chk("t4_b_wb_vld", 128'(wb_vld), 128'(1));
        chk("t4_b_wb_bus", 128'(wb_bus), 128'(wb_exp(b)));
        step(); rsp_vld = 1'b0;

        // Randomized traffic against the scoreboard
        exp_q.delete();
        rsp_cnt = 0; rsp_data = '0;
        @(negedge clk); mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                rsp_vld   = (rsp_cnt == 0);
                rsp_rdata = (rsp_cnt == 0) ? rsp_data : $urandom;
            end else begin
                rsp_vld   = ($urandom_range(0, 9) == 0);
                rsp_rdata = $urandom;
            end
            cur      = rand_instr();
            ex_vld   = ($urandom_range(0, 9) < 7);
            ex_bus   = ex_vec(cur);
            wb_allow = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ex_vld && allow_in) begin
                exp_q.push_back(cur);
                if (cur.ld) begin
                    rsp_cnt  = $urandom_range(1, 4);
                    rsp_data = cur.rdata;
                end
            end
        end
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            step();
            ex_vld = 1'b0; wb_allow = 1'b1;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                rsp_vld   = (rsp_cnt == 0);
                rsp_rdata = rsp_data;
            end else begin
                rsp_vld = 1'b0;
            end
            @(negedge clk);
        end
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
        mon_en = 1'b0;

        // Reset while a load waits; the late response must be ignored
        step(); rsp_vld = 1'b0;
        a = mk(1'b1, 32'h0000_0500, 5'd13, 32'h1357_9BDF);
        ex_vld = 1'b1; ex_bus = ex_vec(a);
        step(); ex_vld = 1'b0;
        @(negedge clk); chk("t6_wait_allow", 128'(allow_in), 128'(0));
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_wb_vld", 128'(wb_vld), 128'(0));
        chk("t6_rst_allow", 128'(allow_in), 128'(1));
        chk("t6_rst_wb_bus", 128'(wb_bus), 128'(0));
        chk("t6_rst_by_bus", 128'(by_bus), 128'(0));
        @(negedge clk); reset = 1'b1;
        step(); rsp_vld = 1'b1; rsp_rdata = a.rdata;
        @(negedge clk);
        chk("t6_late_wb_vld", 128'(wb_vld), 128'(0));
        chk("t6_late_allow", 128'(allow_in), 128'(1));
        chk("t6_late_wb_bus", 128'(wb_bus), 128'(0));
        step(); rsp_vld = 1'b0;
        @(negedge clk);
        chk("t6_late_wb_bus_after", 128'(wb_bus), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
